// File: rtl/relu_infer_seq.sv
// relu_infer_seq
// Sequencer wrapped around the fix14 ReLU inference engine and its output
// select mux. One request clears the engine, pulses its start, waits for done
// under a watchdog, sweeps out_idx over every class score and returns the
// argmax class and score on a valid/ready result channel.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-low
//   req_valid  inference request            req_ready  request can be accepted
//   abort      synchronous abort to IDLE    busy       sequencer not in IDLE
//   eng_reset  engine clear pulse           eng_start  engine start pulse
//   eng_done   engine completion (level or pulse)
//   out_idx    engine output-select index   eng_out    selected score (comb.)
//   res_valid  result available             res_ready  result consumed
//   res_class  argmax index                 res_score  winning signed score
//   res_err    result is a watchdog timeout
module relu_infer_seq #(
    parameter int DATA_WIDTH  = 14,
    parameter int NUM_CLASSES = 10,
    parameter int CNT_WIDTH   = 20,
    parameter int TIMEOUT     = 600000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  abort,
    output logic                  eng_reset,
    output logic                  eng_start,
    input  logic                  eng_done,
    output logic [3:0]            out_idx,
    input  logic [DATA_WIDTH-1:0] eng_out,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [3:0]            res_class,
    output logic [DATA_WIDTH-1:0] res_score,
    output logic                  res_err,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        GO,
        WAIT,
        SCAN,
        RESULT
    } state_t;

    localparam logic [3:0]           LAST_IDX  = 4'(NUM_CLASSES - 1);
    localparam logic [CNT_WIDTH-1:0] WD_LAST   = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit                   WD_ENABLE = (TIMEOUT != 0);

    state_t                       state;
    state_t                       state_next;
    logic [CNT_WIDTH-1:0]         watchdog;
    logic [3:0]                   idx;
    logic signed [DATA_WIDTH-1:0] best;
    logic [3:0]                   best_idx;
    logic signed [DATA_WIDTH-1:0] score_in;
    logic                         take;
    logic                         scan_last;
    logic                         wd_expired;
    logic                         abort_hit;

    // Index 0 always seeds the running maximum; later indices replace it only
    // on a strictly greater signed score, so ties keep the lower index.
    assign score_in   = $signed(eng_out);
    assign take       = (idx == 4'd0) || (score_in > best);
    assign scan_last  = (idx == LAST_IDX);
    assign wd_expired = WD_ENABLE && (watchdog == WD_LAST);
    assign abort_hit  = abort && (state != IDLE);
    assign out_idx    = idx;
    assign busy       = (state != IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake/pulse outputs. Outputs are decoded from the
    // state so that async reset returns them to their idle values at once.
    // Abort overrides every transition and issues its own engine clear.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        eng_reset  = 1'b0;
        eng_start  = 1'b0;
        res_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_next = CLR;
            end
            CLR: begin
                eng_reset  = 1'b1;
                state_next = GO;
            end
            GO: begin
                eng_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    state_next = SCAN;
                end else if (wd_expired) begin
                    state_next = RESULT;
                end
            end
            SCAN: begin
                if (scan_last) state_next = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_hit) begin
            state_next = IDLE;
            eng_reset  = 1'b1;
        end
    end

    // Datapath: watchdog, scan index, running maximum and the result
    // registers. The last scan cycle folds its own sample into the result
    // directly, so RESULT starts the cycle after index NUM_CLASSES-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            watchdog  <= '0;
            idx       <= 4'd0;
            best      <= '0;
            best_idx  <= 4'd0;
            res_class <= 4'd0;
            res_score <= '0;
            res_err   <= 1'b0;
        end else if (abort_hit) begin
            idx       <= 4'd0;
            res_class <= 4'd0;
            res_score <= '0;
            res_err   <= 1'b0;
        end else begin
            case (state)
                GO: begin
                    watchdog <= '0;
                end
                WAIT: begin
                    watchdog <= watchdog + CNT_WIDTH'(1);
                    if (!eng_done && wd_expired) begin
                        res_err   <= 1'b1;
                        res_class <= 4'd0;
                        res_score <= '0;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best     <= score_in;
                        best_idx <= idx;
                    end
                    if (scan_last) begin
                        idx       <= 4'd0;
                        res_class <= take ? idx : best_idx;
                        res_score <= take ? score_in : best;
                        res_err   <= 1'b0;
                    end else begin
                        idx <= idx + 4'd1;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        res_class <= 4'd0;
                        res_score <= '0;
                        res_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_infer_seq.sv
// tb_relu_infer_seq
// Self-checking bench for relu_infer_seq. A behavioural engine model drives
// eng_done and eng_out; a timeline model predicts every DUT output each cycle,
// and directed tests pin latency and results with hand-computed literals.
module tb_relu_infer_seq;

    localparam int DW  = 14;
    localparam int NC  = 10;
    localparam int TMO = 100;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          abort;
    logic          eng_reset;
    logic          eng_start;
    logic          eng_done;
    logic [3:0]    out_idx;
    logic [DW-1:0] eng_out;
    logic          res_valid;
    logic          res_ready;
    logic [3:0]    res_class;
    logic [DW-1:0] res_score;
    logic          res_err;
    logic          busy;

    int checks;
    int errors;
    int scores [NC];
    int eng_delay;

    relu_infer_seq #(
        .DATA_WIDTH (DW),
        .NUM_CLASSES(NC),
        .CNT_WIDTH  (20),
        .TIMEOUT    (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .abort    (abort),
        .eng_reset(eng_reset),
        .eng_start(eng_start),
        .eng_done (eng_done),
        .out_idx  (out_idx),
        .eng_out  (eng_out),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_class(res_class),
        .res_score(res_score),
        .res_err  (res_err),
        .busy     (busy)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine output mux: the score selected by out_idx, combinationally.
    always_comb begin
        eng_out = '0;
        if (out_idx < 4'(NC)) eng_out = DW'(scores[out_idx]);
    end

    // Engine model: done rises eng_delay cycles after the start cycle and is
    // held until the engine is cleared. eng_delay of 0 means never done.
    initial begin : engine
        bit saw_start;
        bit saw_clear;
        int remaining;
        eng_done  = 1'b0;
        remaining = 0;
        forever begin
            @(negedge clk);
            saw_start = eng_start;
            saw_clear = eng_reset;
            @(posedge clk);
            #1;
            if (!rst || saw_clear) begin
                eng_done  = 1'b0;
                remaining = 0;
            end else if (saw_start && eng_delay > 0) begin
                remaining = eng_delay - 1;
                if (remaining == 0) eng_done = 1'b1;
            end else if (remaining > 0) begin
                remaining--;
                if (remaining == 0) eng_done = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Drive the three control inputs just after a rising edge.
    task automatic applyStimulus(input bit rv, input bit rr, input bit ab);
        @(posedge clk);
        #1;
        req_valid = rv;
        res_ready = rr;
        abort     = ab;
    endtask

    // Argmax straight from the rule: first maximum wins.
    function automatic void argmax(output int cls, output int best);
        cls  = 0;
        best = scores[0];
        for (int i = 1; i < NC; i++) begin
            if (scores[i] > best) begin
                best = scores[i];
                cls  = i;
            end
        end
    endfunction

    // Timeline model: tracks cycles since acceptance, when the score sweep
    // begins and whether a result is being presented; checks all outputs
    // mid-cycle, then advances using the inputs seen in that cycle.
    initial begin : model
        bit active;
        bit in_res;
        int t;
        int scan_start;
        int m_cls;
        int m_score;
        int m_err;
        int e_idx;
        active = 0;
        in_res = 0;
        t = 0;
        scan_start = -1;
        m_cls = 0;
        m_score = 0;
        m_err = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                active = 0;
                in_res = 0;
            end
            e_idx = 0;
            if (active && !in_res && scan_start >= 0 && t >= scan_start) e_idx = t - scan_start;
            checkOutput("m_req_ready", req_ready, !active);
            checkOutput("m_busy", busy, active);
            checkOutput("m_eng_reset", eng_reset, active && (t == 1 || abort));
            checkOutput("m_eng_start", eng_start, active && t == 2);
            checkOutput("m_out_idx", out_idx, e_idx);
            checkOutput("m_res_valid", res_valid, active && in_res);
            checkOutput("m_res_class", res_class, (active && in_res) ? m_cls : 0);
            checkOutput("m_res_score", int'($signed(res_score)), (active && in_res) ? m_score : 0);
            checkOutput("m_res_err", res_err, (active && in_res) ? m_err : 0);
            if (rst) begin
                if (!active) begin
                    if (req_valid) begin
                        active     = 1;
                        in_res     = 0;
                        t          = 1;
                        scan_start = -1;
                    end
                end else if (abort) begin
                    active = 0;
                end else begin
                    if (in_res) begin
                        if (res_ready) active = 0;
                    end else if (scan_start >= 0) begin
                        if (t == scan_start + NC - 1) begin
                            in_res = 1;
                            m_err  = 0;
                            argmax(m_cls, m_score);
                        end
                    end else if (t >= 3) begin
                        if (eng_done) begin
                            scan_start = t + 1;
                        end else if (t - 2 == TMO) begin
                            in_res  = 1;
                            m_err   = 1;
                            m_cls   = 0;
                            m_score = 0;
                        end
                    end
                    t++;
                end
            end
        end
    end

    // Issue one request and wait for its result; pins latency, pulse
    // positions and the result fields against hand-computed literals.
    task automatic runRequest(input string name, input int exp_lat, input int exp_cls,
                              input int exp_score, input int exp_err);
        bit seen;
        int k;
        int clr_at;
        int go_at;
        applyStimulus(1, 0, 0);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (req_ready) seen = 1;
        end
        checkOutput({name, "_accept"}, seen, 1);
        applyStimulus(0, 0, 0);
        k = 1;
        clr_at = -1;
        go_at = -1;
        seen = 0;
        while (!seen && k < 400) begin
            @(negedge clk);
            if (eng_reset && clr_at < 0) clr_at = k;
            if (eng_start && go_at < 0) go_at = k;
            if (res_valid) seen = 1;
            else k++;
        end
        checkOutput({name, "_latency"}, seen ? k : -1, exp_lat);
        checkOutput({name, "_clr_cycle"}, clr_at, 1);
        checkOutput({name, "_go_cycle"}, go_at, 2);
        checkOutput({name, "_class"}, res_class, exp_cls);
        checkOutput({name, "_score"}, int'($signed(res_score)), exp_score);
        checkOutput({name, "_err"}, res_err, exp_err);
    endtask

    task automatic releaseResult(input string name);
        applyStimulus(0, 1, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput({name, "_valid_drop"}, res_valid, 0);
        checkOutput({name, "_idle"}, req_ready, 1);
    endtask

    // Hard stop in case anything ever hangs.
    initial begin : time_limit
        #300000;
        $display("[TB] FAIL time_limit: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        bit stable;
        bit seen;
        int cnt;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        req_valid = 1'b0;
        res_ready = 1'b0;
        abort     = 1'b0;
        eng_delay = 0;
        scores    = '{3, -2, 100, 7, 0, 99, -8191, 5, 1, 2};

        #2;
        checkOutput("reset_req_ready", req_ready, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_res_valid", res_valid, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // Nominal: done 50 cycles after start, winner is index 2.
        eng_delay = 50;
        runRequest("nominal", 63, 2, 100, 0);

        // Backpressure: result held stable with req_ready low.
        stable = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!res_valid || req_ready || res_class != 4'd2 || res_score != 14'd100 || res_err)
                stable = 0;
        end
        checkOutput("backpressure_stable", stable, 1);

        // Request raised together with the handshake is taken one cycle later.
        applyStimulus(1, 1, 0);
        @(negedge clk);
        checkOutput("no_accept_in_result", req_ready, 0);
        applyStimulus(1, 0, 0);
        @(negedge clk);
        checkOutput("accept_after_handshake", req_ready, 1);
        checkOutput("valid_cleared", res_valid, 0);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("clr_after_accept", eng_reset, 1);

        // Abort that request in the middle of the sweep.
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (out_idx == 4'd4) seen = 1;
        end
        checkOutput("reach_idx4", seen, 1);
        applyStimulus(0, 0, 1);
        @(negedge clk);
        checkOutput("abort_at_idx5", out_idx, 5);
        checkOutput("abort_clr_pulse", eng_reset, 1);
        applyStimulus(0, 0, 0);
        @(negedge clk);
        checkOutput("abort_idle", busy, 0);
        checkOutput("abort_clr_single", eng_reset, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (res_valid || busy) cnt++;
        end
        checkOutput("abort_no_result", cnt, 0);

        // Every score equal and negative: index 0 wins.
        scores    = '{-5, -5, -5, -5, -5, -5, -5, -5, -5, -5};
        eng_delay = 5;
        runRequest("all_neg", 18, 0, -5, 0);
        releaseResult("all_neg");

        // Maximum positive score at 4 and 9: lower index wins.
        scores    = '{10, -3, 200, 8190, 8191, 0, -1, 8000, 7, 8191};
        eng_delay = 3;
        runRequest("tie_max", 16, 4, 8191, 0);
        releaseResult("tie_max");

        // Engine never finishes: watchdog result after 100 wait cycles.
        eng_delay = 0;
        runRequest("timeout", 103, 0, 0, 1);
        releaseResult("timeout");

        // Done exactly on the final watchdog cycle still produces a result.
        scores    = '{-100, -50, -7, -1, -2, -3, -8000, -8191, -1, -9};
        eng_delay = 100;
        runRequest("done_last", 113, 3, -1, 0);
        releaseResult("done_last");

        // Asynchronous reset in the middle of the wait.
        eng_delay = 0;
        applyStimulus(1, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0);
        repeat (20) @(negedge clk);
        checkOutput("wait_busy", busy, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("async_busy", busy, 0);
        checkOutput("async_req_ready", req_ready, 1);
        checkOutput("async_eng_start", eng_start, 0);
        checkOutput("async_eng_reset", eng_reset, 0);
        checkOutput("async_out_idx", out_idx, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;

        // Recovery after reset.
        scores    = '{3, -2, 100, 7, 0, 99, -8191, 5, 1, 2};
        eng_delay = 2;
        runRequest("recover", 15, 2, 100, 0);
        releaseResult("recover");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/relu_infer_seq.md
Name: relu_infer_seq

Overview:
- Sequencer wrapped around the fix14 ReLU inference engine and its 10-way output-select mux.
- Accepts one inference request and clears the engine, then pulses its start. Waits for done under a watchdog.
- Then sweeps out_idx 0..9 and reduces the 10 signed scores to an argmax class. Returns the class and score on a valid/ready result channel.

Parameters:
- DATA_WIDTH, 14, signed score width; matches the engine.
- NUM_CLASSES, 10, number of output scores swept; must be ≤16.
- CNT_WIDTH, 20, width of the watchdog counter.
- TIMEOUT, 600000, max cycles in WAIT before error; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- req_valid  in  1  inference request.
- req_ready  out  1  sequencer can accept a request.
- abort  in  1  synchronous abort; returns to IDLE.
- eng_reset  out  1  engine clear, 1-cycle pulse.
- eng_start  out  1  engine start, 1-cycle pulse.
- eng_done  in  1  engine completion, level or pulse.
- out_idx  out  4  engine output-select index.
- eng_out  in  DATA_WIDTH  selected engine score, combinational from out_idx.
- res_valid  out  1  result available.
- res_ready  in  1  result consumed.
- res_class  out  4  argmax index.
- res_score  out  DATA_WIDTH  winning score (signed).
- res_err  out  1  result is a timeout error.
- busy  out  1  state ≠ IDLE.

Behaviour:
- Reset (rst low, async) forces:
  - state=IDLE;
  - all outputs 0, except req_ready=1;
  - out_idx=0, counters 0.
- States and transitions:
  - IDLE: req_ready=1. req_valid&req_ready → CLR.
  - CLR: eng_reset=1 for exactly one cycle → GO.
  - GO: eng_start=1 for exactly one cycle; watchdog cleared → WAIT.
  - WAIT: watchdog increments each cycle.
    - eng_done=1 → SCAN with out_idx=0.
    - Else if TIMEOUT≠0 and watchdog==TIMEOUT-1 → RESULT with res_err=1, res_class=0, res_score=0.
    - eng_done and timeout in the same cycle: done wins.
  - SCAN: one index per cycle. eng_out is sampled in the same cycle out_idx is driven.
    - At idx 0: best=eng_out, best_idx=0.
    - At idx k>0: if eng_out > best (signed, strict), update best and best_idx. Ties keep the lower index.
    - After sampling idx NUM_CLASSES-1 → RESULT. out_idx returns to 0.
    - SCAN lasts exactly NUM_CLASSES cycles.
  - RESULT: res_valid=1; res_class/res_score/res_err are stable while res_valid is high. res_valid&res_ready → IDLE.
    - res_valid, res_class, res_score and res_err are cleared on leaving RESULT.
- Latency: accept → res_valid = 2 (CLR,GO) + engine cycles in WAIT + NUM_CLASSES + 1 registered cycles.
- out_idx is held at 0 outside SCAN and never exceeds NUM_CLASSES-1.
- Request accepted only in IDLE. A new request in the same cycle as res_ready is not accepted; it is accepted in the following IDLE cycle.
- abort, in any state other than IDLE:
  - next state IDLE;
  - eng_reset pulses 1 cycle;
  - no result is produced;
  - res_valid drops.
- abort in IDLE is ignored. abort has priority over all other transitions.
- eng_done outside WAIT is ignored.
- Comparisons are full-width signed. Negative scores are legal: ReLU is not assumed on the final layer.

Test Plan:
- Nominal:
  - Request; engine model asserts done 50 cycles after start.
  - Scores are [3,-2,100,7,0,99,-8191,5,1,2].
  - Expect res_class=2, res_score=100, res_err=0.
  - res_valid rises exactly 2+50+10+1 cycles after acceptance.
  - eng_reset and eng_start are single-cycle, in order.
- Ties and negatives:
  - All scores -5 → res_class=0, res_score=-5.
  - Scores with index 4 and 9 both 8191 → res_class=4.
- Timeout:
  - TIMEOUT=100; eng_done never asserted.
  - Expect res_valid with res_err=1 after 100 WAIT cycles, then return to IDLE on res_ready.
  - Separately, done on the final watchdog cycle → normal result with res_err=0.
- Backpressure:
  - Hold res_ready=0 for 20 cycles; outputs stay stable and req_ready=0.
  - req_valid held high is accepted on the cycle after the res_ready handshake.
- Abort/reset mid-operation:
  - abort during SCAN at out_idx=5 → IDLE next cycle, one eng_reset pulse, no res_valid.
  - rst low during WAIT → immediate IDLE, all outputs at reset values, asynchronous to clk.
